// File: rtl/axis_event_arbiter.sv
// axis_event_arbiter: packet-granular round-robin merge of N_SRC AXI-stream sources onto one link.
// Define AXIS_ARB_TDEST_EN to add the m_TDEST source-tag output.
module axis_event_arbiter #(
   parameter int N_SRC = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     ARESETn,
   input  logic [N_SRC-1:0]         s_TVALID,
   output logic [N_SRC-1:0]         s_TREADY,
   input  logic [N_SRC*128-1:0]     s_TDATA,
   input  logic [N_SRC*16-1:0]      s_TKEEP,
   input  logic [N_SRC*16-1:0]      s_TSTRB,
   input  logic [N_SRC-1:0]         s_TLAST,
   input  logic [N_SRC*11-1:0]      s_TID,
   output logic                     m_TVALID,
   input  logic                     m_TREADY,
   output logic [127:0]             m_TDATA,
   output logic [15:0]              m_TKEEP,
   output logic [15:0]              m_TSTRB,
   output logic                     m_TLAST,
   output logic [10:0]              m_TID,
   output logic                     busy,
   output logic [N_SRC-1:0]         grant,
   output logic [N_SRC*CNT_W-1:0]   evt_cnt
`ifdef AXIS_ARB_TDEST_EN
   ,
   output logic [$clog2(N_SRC)-1:0] m_TDEST
`endif
);

   localparam int IDX_W = $clog2(N_SRC);

   typedef enum logic {S_IDLE, S_XFER} state_t;

   state_t           state_q, state_d;
   logic [N_SRC-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q [N_SRC];
   logic [CNT_W-1:0] cnt_d [N_SRC];
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             last_hs;

   // Grant is one-hot and all-zero in IDLE, so the mux alone forces m_* to 0 outside XFER.
   always_comb begin
      m_TVALID = 1'b0;
      m_TDATA  = '0;
      m_TKEEP  = '0;
      m_TSTRB  = '0;
      m_TLAST  = 1'b0;
      m_TID    = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            m_TVALID = s_TVALID[i];
            m_TDATA  = s_TDATA[i*128 +: 128];
            m_TKEEP  = s_TKEEP[i*16 +: 16];
            m_TSTRB  = s_TSTRB[i*16 +: 16];
            m_TLAST  = s_TLAST[i];
            m_TID    = s_TID[i*11 +: 11];
         end
      end
   end

   assign s_TREADY = grant_q & {N_SRC{m_TREADY}};
   assign last_hs  = (state_q == S_XFER) & m_TVALID & m_TREADY & m_TLAST;
   assign busy     = (state_q == S_XFER);
   assign grant    = grant_q;

`ifdef AXIS_ARB_TDEST_EN
   assign m_TDEST = (state_q == S_XFER) ? gidx_q : '0;
`endif

   for (genvar g = 0; g < N_SRC; g++) begin : g_cnt_out
      assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      found    = 1'b0;
      cand     = '0;
      case (state_q)
         S_IDLE: begin
            // First valid source at or after rr_ptr, wrapping modulo N_SRC.
            for (int k = 0; k < N_SRC; k++) begin
               cand = IDX_W'((int'(rr_ptr_q) + k) % N_SRC);
               if (!found && s_TVALID[cand]) begin
                  found  = 1'b1;
                  gidx_d = cand;
               end
            end
            if (found) begin
               state_d         = S_XFER;
               grant_d         = '0;
               grant_d[gidx_d] = 1'b1;
            end
         end
         S_XFER: begin
            if (last_hs) begin
               state_d       = S_IDLE;
               grant_d       = '0;
               rr_ptr_d      = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
               cnt_d[gidx_q] = cnt_q[gidx_q] + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_axis_event_arbiter.sv
// Directed testbench for axis_event_arbiter (N_SRC=4, narrow counters so wrap is reachable).
// Checks m_TDEST as well when AXIS_ARB_TDEST_EN is defined.
module tb_axis_event_arbiter;

   localparam int N  = 4;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              ARESETn;
   logic [N-1:0]      s_TVALID;
   logic [N-1:0]      s_TREADY;
   logic [N*128-1:0]  s_TDATA;
   logic [N*16-1:0]   s_TKEEP;
   logic [N*16-1:0]   s_TSTRB;
   logic [N-1:0]      s_TLAST;
   logic [N*11-1:0]   s_TID;
   logic              m_TVALID;
   logic              m_TREADY;
   logic [127:0]      m_TDATA;
   logic [15:0]       m_TKEEP;
   logic [15:0]       m_TSTRB;
   logic              m_TLAST;
   logic [10:0]       m_TID;
   logic              busy;
   logic [N-1:0]      grant;
   logic [N*CW-1:0]   evt_cnt;
`ifdef AXIS_ARB_TDEST_EN
   logic [1:0]        m_TDEST;
`endif

   int total = 0;
   int bad   = 0;

   axis_event_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
      .clk(clk), .ARESETn(ARESETn),
      .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
      .s_TKEEP(s_TKEEP), .s_TSTRB(s_TSTRB), .s_TLAST(s_TLAST), .s_TID(s_TID),
      .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .m_TDATA(m_TDATA),
      .m_TKEEP(m_TKEEP), .m_TSTRB(m_TSTRB), .m_TLAST(m_TLAST), .m_TID(m_TID),
      .busy(busy), .grant(grant), .evt_cnt(evt_cnt)
`ifdef AXIS_ARB_TDEST_EN
      , .m_TDEST(m_TDEST)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] dat(int s, int b);
      return {8'(s), 8'(b), {14{8'hA5}}};
   endfunction

   function automatic logic [15:0] kp(int s, int b);
      return 16'hFFFF >> (s + b);
   endfunction

   function automatic logic [10:0] tid(int s, int b);
      return 11'(s * 16 + b);
   endfunction

   function automatic logic [CW-1:0] cnt_of(int s);
      return evt_cnt[s*CW +: CW];
   endfunction

   task automatic set_src(int s, logic v, int b, logic l);
      s_TVALID[s]          = v;
      s_TDATA[s*128 +: 128] = dat(s, b);
      s_TKEEP[s*16 +: 16]  = kp(s, b);
      s_TSTRB[s*16 +: 16]  = ~kp(s, b);
      s_TLAST[s]           = l;
      s_TID[s*11 +: 11]    = tid(s, b);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ARESETn  = 1'b0;
      m_TREADY = 1'b0;
      s_TVALID = '0; s_TDATA = '0; s_TKEEP = '0; s_TSTRB = '0; s_TLAST = '0; s_TID = '0;
      cyc();
      #1;
      total++; if (m_TVALID !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%0h want=0", m_TVALID); end
      total++; if (s_TREADY !== 4'b0) begin bad++; $display("FAIL rst_sready got=%0h want=0", s_TREADY); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant got=%0h want=0", grant); end
      total++; if (evt_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0h want=0", evt_cnt); end
      total++; if (m_TDATA !== '0) begin bad++; $display("FAIL rst_mdata got=%0h want=0", m_TDATA); end
      cyc();
      ARESETn = 1'b1;
   endtask

   task automatic test_single_source();
      cyc(); m_TREADY = 1'b1; set_src(0, 1'b1, 0, 1'b0); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_busy got=%0h want=0", busy); end
      total++; if (m_TVALID !== 1'b0) begin bad++; $display("FAIL t1_idle_mvalid got=%0h want=0", m_TVALID); end
      total++; if (s_TREADY !== 4'b0) begin bad++; $display("FAIL t1_idle_sready got=%0h want=0", s_TREADY); end
      cyc(); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL t1_grant got=%0h want=1", grant); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0h want=1", busy); end
      total++; if (m_TDATA !== dat(0, 0)) begin bad++; $display("FAIL t1_beat0 got=%0h want=%0h", m_TDATA, dat(0, 0)); end
      total++; if (m_TLAST !== 1'b0) begin bad++; $display("FAIL t1_last0 got=%0h want=0", m_TLAST); end
      cyc(); set_src(0, 1'b1, 1, 1'b0); #1;
      total++; if (m_TDATA !== dat(0, 1)) begin bad++; $display("FAIL t1_beat1 got=%0h want=%0h", m_TDATA, dat(0, 1)); end
      total++; if (m_TVALID !== 1'b1) begin bad++; $display("FAIL t1_mvalid1 got=%0h want=1", m_TVALID); end
      cyc(); set_src(0, 1'b1, 2, 1'b1); #1;
      total++; if (m_TLAST !== 1'b1) begin bad++; $display("FAIL t1_last2 got=%0h want=1", m_TLAST); end
      total++; if (m_TKEEP !== kp(0, 2)) begin bad++; $display("FAIL t1_keep got=%0h want=%0h", m_TKEEP, kp(0, 2)); end
      total++; if (m_TSTRB !== ~kp(0, 2)) begin bad++; $display("FAIL t1_strb got=%0h want=%0h", m_TSTRB, ~kp(0, 2)); end
      total++; if (s_TREADY !== 4'b0001) begin bad++; $display("FAIL t1_sready got=%0h want=1", s_TREADY); end
      total++; if (cnt_of(0) !== 4'd0) begin bad++; $display("FAIL t1_cnt_pre got=%0h want=0", cnt_of(0)); end
      cyc(); set_src(0, 1'b0, 0, 1'b0); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_end_busy got=%0h want=0", busy); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL t1_end_grant got=%0h want=0", grant); end
      total++; if (cnt_of(0) !== 4'd1) begin bad++; $display("FAIL t1_cnt got=%0h want=1", cnt_of(0)); end
   endtask

   task automatic test_round_robin();
      cyc(); ARESETn = 1'b0; set_src(0, 1'b1, 0, 1'b0); set_src(2, 1'b1, 0, 1'b0); #1;
      cyc(); ARESETn = 1'b1; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_idle got=%0h want=0", busy); end
      total++; if (cnt_of(0) !== 4'd0) begin bad++; $display("FAIL t2_cnt_rst got=%0h want=0", cnt_of(0)); end
      cyc(); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL t2_grant0 got=%0h want=1", grant); end
      total++; if (s_TREADY !== 4'b0001) begin bad++; $display("FAIL t2_sready0 got=%0h want=1", s_TREADY); end
      total++; if (m_TDATA !== dat(0, 0)) begin bad++; $display("FAIL t2_data00 got=%0h want=%0h", m_TDATA, dat(0, 0)); end
      cyc(); set_src(0, 1'b1, 1, 1'b1); #1;
      total++; if (m_TDATA !== dat(0, 1)) begin bad++; $display("FAIL t2_data01 got=%0h want=%0h", m_TDATA, dat(0, 1)); end
      total++; if (m_TLAST !== 1'b1) begin bad++; $display("FAIL t2_last0 got=%0h want=1", m_TLAST); end
      cyc(); set_src(0, 1'b0, 0, 1'b0); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_bubble got=%0h want=0", busy); end
      total++; if (m_TVALID !== 1'b0) begin bad++; $display("FAIL t2_bubble_mv got=%0h want=0", m_TVALID); end
      total++; if (cnt_of(0) !== 4'd1) begin bad++; $display("FAIL t2_cnt0 got=%0h want=1", cnt_of(0)); end
      cyc(); #1;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL t2_grant2 got=%0h want=4", grant); end
      total++; if (m_TDATA !== dat(2, 0)) begin bad++; $display("FAIL t2_data20 got=%0h want=%0h", m_TDATA, dat(2, 0)); end
      cyc(); set_src(2, 1'b1, 1, 1'b1); #1;
      total++; if (m_TID !== tid(2, 1)) begin bad++; $display("FAIL t2_tid got=%0h want=%0h", m_TID, tid(2, 1)); end
      cyc(); set_src(1, 1'b1, 0, 1'b1); set_src(2, 1'b1, 0, 1'b1); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_bubble2 got=%0h want=0", busy); end
      total++; if (cnt_of(2) !== 4'd1) begin bad++; $display("FAIL t2_cnt2 got=%0h want=1", cnt_of(2)); end
      cyc(); #1;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL t2_rr_grant1 got=%0h want=2", grant); end
      cyc(); set_src(1, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(1) !== 4'd1) begin bad++; $display("FAIL t2_cnt1 got=%0h want=1", cnt_of(1)); end
      cyc(); #1;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL t2_rr_grant2 got=%0h want=4", grant); end
      cyc(); set_src(2, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(2) !== 4'd2) begin bad++; $display("FAIL t2_cnt2b got=%0h want=2", cnt_of(2)); end
   endtask

   task automatic test_last_backpressure();
      cyc(); m_TREADY = 1'b1; set_src(1, 1'b1, 0, 1'b0); #1;
      cyc(); #1;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL t3_grant got=%0h want=2", grant); end
      total++; if (m_TDATA !== dat(1, 0)) begin bad++; $display("FAIL t3_data0 got=%0h want=%0h", m_TDATA, dat(1, 0)); end
      cyc(); set_src(1, 1'b1, 1, 1'b1); m_TREADY = 1'b0; #1;
      total++; if (s_TREADY !== 4'b0) begin bad++; $display("FAIL t3_sready_lo got=%0h want=0", s_TREADY); end
      for (int k = 0; k < 3; k++) begin
         cyc(); #1;
         total++; if (m_TDATA !== dat(1, 1)) begin bad++; $display("FAIL t3_hold_data got=%0h want=%0h", m_TDATA, dat(1, 1)); end
         total++; if (m_TLAST !== 1'b1) begin bad++; $display("FAIL t3_hold_last got=%0h want=1", m_TLAST); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL t3_hold_busy got=%0h want=1", busy); end
         total++; if (grant !== 4'b0010) begin bad++; $display("FAIL t3_hold_grant got=%0h want=2", grant); end
         total++; if (cnt_of(1) !== 4'd1) begin bad++; $display("FAIL t3_hold_cnt got=%0h want=1", cnt_of(1)); end
      end
      cyc(); m_TREADY = 1'b1; #1;
      total++; if (s_TREADY !== 4'b0010) begin bad++; $display("FAIL t3_sready_hi got=%0h want=2", s_TREADY); end
      cyc(); set_src(1, 1'b0, 0, 1'b0); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_end_busy got=%0h want=0", busy); end
      total++; if (cnt_of(1) !== 4'd2) begin bad++; $display("FAIL t3_cnt got=%0h want=2", cnt_of(1)); end
      cyc(); #1;
      total++; if (cnt_of(1) !== 4'd2) begin bad++; $display("FAIL t3_cnt_once got=%0h want=2", cnt_of(1)); end
   endtask

   task automatic test_stall_no_release();
      cyc(); set_src(0, 1'b1, 0, 1'b0); #1;
      cyc(); set_src(3, 1'b1, 0, 1'b1); #1;
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL t4_grant got=%0h want=1", grant); end
      total++; if (s_TREADY !== 4'b0001) begin bad++; $display("FAIL t4_sready got=%0h want=1", s_TREADY); end
      for (int k = 0; k < 2; k++) begin
         cyc(); set_src(0, 1'b0, 1, 1'b0); #1;
         total++; if (m_TVALID !== 1'b0) begin bad++; $display("FAIL t4_stall_mv got=%0h want=0", m_TVALID); end
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL t4_stall_grant got=%0h want=1", grant); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_stall_busy got=%0h want=1", busy); end
         total++; if (s_TREADY[3] !== 1'b0) begin bad++; $display("FAIL t4_sready3 got=%0h want=0", s_TREADY[3]); end
      end
      cyc(); set_src(0, 1'b1, 1, 1'b1); #1;
      total++; if (m_TDATA !== dat(0, 1)) begin bad++; $display("FAIL t4_data01 got=%0h want=%0h", m_TDATA, dat(0, 1)); end
      cyc(); set_src(0, 1'b0, 0, 1'b0); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_bubble got=%0h want=0", busy); end
      total++; if (cnt_of(0) !== 4'd2) begin bad++; $display("FAIL t4_cnt0 got=%0h want=2", cnt_of(0)); end
      cyc(); #1;
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL t4_grant3 got=%0h want=8", grant); end
      total++; if (m_TDATA !== dat(3, 0)) begin bad++; $display("FAIL t4_data30 got=%0h want=%0h", m_TDATA, dat(3, 0)); end
      cyc(); set_src(3, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(3) !== 4'd1) begin bad++; $display("FAIL t4_cnt3 got=%0h want=1", cnt_of(3)); end
   endtask

   task automatic test_reset_mid_packet();
      cyc(); set_src(2, 1'b1, 0, 1'b1); #1;
      cyc(); set_src(3, 1'b1, 0, 1'b0); #1;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL t5_grant2 got=%0h want=4", grant); end
      cyc(); set_src(2, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(2) !== 4'd3) begin bad++; $display("FAIL t5_cnt2 got=%0h want=3", cnt_of(2)); end
      cyc(); #1;
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL t5_grant3 got=%0h want=8", grant); end
      cyc(); set_src(3, 1'b1, 1, 1'b0); ARESETn = 1'b0; #1;
      total++; if (m_TVALID !== 1'b0) begin bad++; $display("FAIL t5_mvalid got=%0h want=0", m_TVALID); end
      total++; if (s_TREADY !== 4'b0) begin bad++; $display("FAIL t5_sready got=%0h want=0", s_TREADY); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL t5_grant got=%0h want=0", grant); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%0h want=0", busy); end
      total++; if (evt_cnt !== '0) begin bad++; $display("FAIL t5_cnt got=%0h want=0", evt_cnt); end
      cyc(); set_src(3, 1'b1, 0, 1'b1); set_src(1, 1'b1, 0, 1'b1); ARESETn = 1'b1; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_rel_busy got=%0h want=0", busy); end
      cyc(); #1;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL t5_rr0_grant got=%0h want=2", grant); end
      cyc(); set_src(1, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(1) !== 4'd1) begin bad++; $display("FAIL t5_cnt1 got=%0h want=1", cnt_of(1)); end
      cyc(); #1;
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL t5_grant3b got=%0h want=8", grant); end
      cyc(); set_src(3, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(3) !== 4'd1) begin bad++; $display("FAIL t5_cnt3 got=%0h want=1", cnt_of(3)); end
   endtask

   task automatic test_back_to_back_wrap();
      for (int k = 0; k < 15; k++) begin
         cyc(); set_src(3, 1'b1, 0, 1'b1); #1;
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL t6_bubble k=%0d got=%0h want=0", k, busy); end
         total++; if (cnt_of(3) !== CW'(1 + k)) begin bad++; $display("FAIL t6_cnt k=%0d got=%0h want=%0h", k, cnt_of(3), CW'(1 + k)); end
`ifdef AXIS_ARB_TDEST_EN
         total++; if (m_TDEST !== 2'd0) begin bad++; $display("FAIL t6_tdest_idle got=%0h want=0", m_TDEST); end
`endif
         cyc(); #1;
         total++; if (grant !== 4'b1000) begin bad++; $display("FAIL t6_grant k=%0d got=%0h want=8", k, grant); end
         total++; if (m_TVALID !== 1'b1) begin bad++; $display("FAIL t6_mvalid k=%0d got=%0h want=1", k, m_TVALID); end
`ifdef AXIS_ARB_TDEST_EN
         total++; if (m_TDEST !== 2'd3) begin bad++; $display("FAIL t6_tdest got=%0h want=3", m_TDEST); end
`endif
      end
      cyc(); set_src(3, 1'b0, 0, 1'b0); #1;
      total++; if (cnt_of(3) !== 4'd0) begin bad++; $display("FAIL t6_wrap got=%0h want=0", cnt_of(3)); end
      total++; if (cnt_of(1) !== 4'd1) begin bad++; $display("FAIL t6_cnt1 got=%0h want=1", cnt_of(1)); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_source();
      test_round_robin();
      test_last_backpressure();
      test_stall_no_release();
      test_reset_mid_packet();
      test_back_to_back_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
